// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory arbiter: FSM state encoding, owner
// identity and the round-robin pick used at grant time.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT_I = 3'd1,
        ST_GRANT_D = 3'd2,
        ST_DONE_I  = 3'd3,
        ST_DONE_D  = 3'd4,
        ST_ERR_I   = 3'd5,
        ST_ERR_D   = 3'd6
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // On a tie the port that did not own the previous transaction wins.
    function automatic owner_t pick_owner(input logic   i_req,
                                          input logic   d_req,
                                          input owner_t last);
        owner_t sel;
        if (i_req && d_req) begin
            sel = (last == OWN_D) ? OWN_I : OWN_D;
        end else if (i_req) begin
            sel = OWN_I;
        end else begin
            sel = OWN_D;
        end
        return sel;
    endfunction

endpackage

// File: rtl/arb_timer.sv
// Per-transaction wait counter. expired flags the cycle in which the count
// would reach TIMEOUT; TIMEOUT == 0 never expires.
module arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + W'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expired = 1'b0;
        end else begin : g_on
            localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
            assign expired = enable && (count == LAST);
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch
// (I) and load/store (D) ports, with a per-transaction timeout.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int n       = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         i_req,
    input  logic [n-1:0] i_addr,
    output logic         i_done,
    output logic         i_err,
    output logic [n-1:0] i_rdata,

    input  logic         d_req,
    input  logic         d_we,
    input  logic [n-1:0] d_addr,
    input  logic [n-1:0] d_wdata,
    output logic         d_done,
    output logic         d_err,
    output logic [n-1:0] d_rdata,

    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata,

    output logic         busy
);

    state_t state;
    state_t state_nx;
    owner_t last_owner;
    owner_t grant_owner;
    logic   in_grant;
    logic   do_grant;
    logic   expired;

    assign in_grant    = (state == ST_GRANT_I) || (state == ST_GRANT_D);
    assign do_grant    = (state == ST_IDLE) && (i_req || d_req);
    assign grant_owner = pick_owner(i_req, d_req, last_owner);

    // Counting stops on the ack cycle, so an ack on the last allowed cycle wins.
    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == ST_IDLE),
        .enable  (in_grant && !mem_ack),
        .expired (expired)
    );

    // NOTE: state_nx gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (do_grant) begin
                    state_nx = (grant_owner == OWN_I) ? ST_GRANT_I : ST_GRANT_D;
                end
            end
            ST_GRANT_I: begin
                if (mem_ack) begin
                    state_nx = ST_DONE_I;
                end else if (expired) begin
                    state_nx = ST_ERR_I;
                end
            end
            ST_GRANT_D: begin
                if (mem_ack) begin
                    state_nx = ST_DONE_D;
                end else if (expired) begin
                    state_nx = ST_ERR_D;
                end
            end
            ST_DONE_I, ST_DONE_D, ST_ERR_I, ST_ERR_D: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request registers are loaded only at grant, so requester inputs can
    // change freely while a transaction is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= OWN_D;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else if (do_grant) begin
            last_owner <= grant_owner;
            if (grant_owner == OWN_I) begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wdata <= '0;
            end else begin
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if ((state == ST_GRANT_I) && mem_ack) begin
                i_rdata <= mem_rdata;
            end
            if ((state == ST_GRANT_D) && mem_ack && !mem_we) begin
                d_rdata <= mem_rdata;
            end
        end
    end

    // Handshake outputs decode the registered state, so reset clears them
    // without waiting for a clock edge.
    assign mem_req = in_grant;
    assign i_done  = (state == ST_DONE_I);
    assign d_done  = (state == ST_DONE_D);
    assign i_err   = (state == ST_ERR_I);
    assign d_err   = (state == ST_ERR_D);
    assign busy    = (state != ST_IDLE);

endmodule
